// File: rtl/sd_pkg.sv
// sd_pkg: SD CRC generator polynomials and the CRC engine state type.
package sd_pkg;
    localparam logic [6:0]  SD_CRC7_POLY  = 7'h09;
    localparam logic [15:0] SD_CRC16_POLY = 16'h1021;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} crc_state_e;
endpackage

// File: rtl/sd_crc_step.sv
// sd_crc_step: one-bit MSB-first LFSR update of a CRC register.
module sd_crc_step #(
    parameter int              CRC_W = 7,
    parameter logic [CRC_W-1:0] POLY = 7'h09
) (
    input  logic [CRC_W-1:0] crc,
    input  logic             bit_in,
    output logic [CRC_W-1:0] nxt
);
    assign nxt = (crc << 1) ^ ((crc[CRC_W-1] ^ bit_in) ? POLY : '0);
endmodule

// File: rtl/sd_crc_engine.sv
// sd_crc_engine: bit-serial CRC7/CRC16 generator for SD frames.
// Define SD_CRC_CHECK_EN to add the crc_exp input and crc_match result.
module sd_crc_engine
    import sd_pkg::*;
#(
    parameter int               CRC_W  = 7,
    parameter logic [CRC_W-1:0] POLY   = SD_CRC7_POLY,
    parameter int               DATA_W = 8,
    parameter logic [CRC_W-1:0] INIT   = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
`ifdef SD_CRC_CHECK_EN
    input  logic [CRC_W-1:0]  crc_exp,
    output logic              crc_match,
`endif
    output logic              in_ready,
    output logic              busy,
    output logic [CRC_W-1:0]  crc_o,
    output logic              crc_valid
);
    localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    crc_state_e        state;
    logic [CRC_W-1:0]  crc, crc_nxt;
    logic [DATA_W-1:0] sreg;
    logic [BW-1:0]     bitcnt;
    logic              last_q, take;
`ifdef SD_CRC_CHECK_EN
    logic [CRC_W-1:0]  exp_q;
`endif

    // A new beat may land on the final bit of a non-last beat, giving back-to-back beats.
    assign in_ready = !clear && (state == IDLE || (state == SHIFT && bitcnt == '0 && !last_q));
    assign take     = in_valid && in_ready;

    sd_crc_step #(.CRC_W(CRC_W), .POLY(POLY)) u_step (
        .crc(crc), .bit_in(sreg[DATA_W-1]), .nxt(crc_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            crc       <= INIT;
            crc_o     <= '0;
            crc_valid <= 1'b0;
            busy      <= 1'b0;
            sreg      <= '0;
            bitcnt    <= '0;
            last_q    <= 1'b0;
`ifdef SD_CRC_CHECK_EN
            crc_match <= 1'b0;
            exp_q     <= '0;
`endif
        end else if (clear) begin
            state     <= IDLE;
            crc       <= INIT;
            crc_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef SD_CRC_CHECK_EN
            crc_match <= 1'b0;
`endif
        end else begin
            crc_valid <= 1'b0;
`ifdef SD_CRC_CHECK_EN
            crc_match <= 1'b0;
`endif
            case (state)
                IDLE: if (take) state <= SHIFT;
                SHIFT: begin
                    crc    <= crc_nxt;
                    sreg   <= sreg << 1;
                    bitcnt <= bitcnt - 1'b1;
                    if (bitcnt == '0) begin
                        if (last_q) begin
                            state     <= DONE;
                            crc_o     <= crc_nxt;
                            crc_valid <= 1'b1;
`ifdef SD_CRC_CHECK_EN
                            crc_match <= crc_nxt == exp_q;
`endif
                        end else if (!take) begin
                            state <= IDLE;
                        end
                    end
                end
                DONE: begin
                    crc   <= INIT;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // Accepted beats override the shift above.
            if (take) begin
                sreg   <= in_data;
                last_q <= in_last;
                bitcnt <= LAST_BIT;
                busy   <= 1'b1;
`ifdef SD_CRC_CHECK_EN
                if (in_last) exp_q <= crc_exp;
`endif
            end
        end
    end
endmodule
